// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the iterative divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
  localparam int DIV_W_DEFAULT = 32;
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift, trial subtract, select).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH+1:0] shifted, diff;
  // One extra guard bit so the sign of the trial difference is never lost.
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    diff    = shifted - {2'b00, divisor};
    rem_out = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SIGNED_DIV_EN to honour sgn (two's-complement operands); otherwise sgn is ignored.
module iterative_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);
  localparam int CW = cnt_width(WIDTH);
  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d, rem_nx;
  logic [WIDTH-1:0] quo_q, quo_d, quo_nx;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, dz_q, dz_d;
  logic             sgn_eff;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
`ifdef SIGNED_DIV_EN
  assign sgn_eff = sgn;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign sgn_eff    = 1'b0;
`endif
  // The datapath works on magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
  assign dvd_mag = (sgn_eff && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (sgn_eff && divisor[WIDTH-1]) ? -divisor : divisor;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(dvs_q),
    .rem_out(rem_nx),
    .quo_out(quo_nx)
  );
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        in_ready_d = 1'b0;
        cnt_d      = '0;
        rem_d      = '0;
        if (divisor == '0) begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = dividend;
          dz_d        = 1'b1;
          out_valid_d = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH - 1);
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          neg_q_d = sgn_eff & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = sgn_eff & dividend[WIDTH-1];
        end
      end
      RUN: begin
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIX : RUN;
      end
      FIX: begin
        quotient_d  = neg_q_q ? -quo_q : quo_q;
        remainder_d = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        dz_d        = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: randomized and directed checks of iterative_divider against an arithmetic reference.
module tb_iterative_divider;
  localparam int W = 32;
`ifdef SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, sgn, out_valid, out_ready, dz;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  int           n_cmp = 0;
  int           n_bad = 0;
  always #5 clk = ~clk;
  iterative_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .sgn      (sgn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .dz       (dz)
  );
  // Reference: plain language-level division; signed truncates toward zero with remainder taking the dividend's sign.
  function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    z = (d == 0);
    if (z) begin
      q = '1;
      r = n;
    end else if (s && SIGNED_EN) begin
      if (n == {1'b1, {(W-1){1'b0}}} && d == '1) begin
        q = n;
        r = '0;
      end else begin
        q = W'($signed(n) / $signed(d));
        r = W'($signed(n) % $signed(d));
      end
    end else begin
      q = n / d;
      r = n % d;
    end
  endfunction
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s, output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    dividend = n;
    divisor  = d;
    sgn      = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL op_timeout %h/%h: out_valid=%b after %0d cycles, want 1", n, d, out_valid, lat);
    end
  endtask
  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sgn = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 5;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (quotient !== '0) begin n_bad++; $display("FAIL reset_q got %h want 0", quotient); end
    if (remainder !== '0) begin n_bad++; $display("FAIL reset_r got %h want 0", remainder); end
    if (dz !== 1'b0) begin n_bad++; $display("FAIL reset_dz got %b want 0", dz); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_directed;
    logic [W-1:0] tn [8];
    logic [W-1:0] td [8];
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat, elat;
    tn = '{32'd100, 32'd5, 32'd3, 32'd12345, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    td = '{32'd7, 32'd0, 32'd10, 32'd1, 32'd9, 32'hFFFFFFFF, 32'd1, 32'd0};
    for (int i = 0; i < 8; i++) begin
      ref_div(tn[i], td[i], 1'b0, eq, er, ez);
      elat = ez ? 0 : W + 1;
      do_op(tn[i], td[i], 1'b0, lat);
      n_cmp += 4;
      if (quotient !== eq) begin n_bad++; $display("FAIL dir%0d_q %h/%h got %h want %h", i, tn[i], td[i], quotient, eq); end
      if (remainder !== er) begin n_bad++; $display("FAIL dir%0d_r %h/%h got %h want %h", i, tn[i], td[i], remainder, er); end
      if (dz !== ez) begin n_bad++; $display("FAIL dir%0d_dz got %b want %b", i, dz, ez); end
      if (lat !== elat) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); end
      consume();
    end
  endtask
  task automatic test_back_pressure;
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    ref_div(32'd1000003, 32'd97, 1'b0, eq, er, ez);
    do_op(32'd1000003, 32'd97, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = $urandom;
      divisor  = $urandom_range(1, 1000);
      @(posedge clk);
      #1;
      n_cmp += 4;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp%0d_out_valid got %b want 1", i, out_valid); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
      if (quotient !== eq) begin n_bad++; $display("FAIL bp%0d_q got %h want %h", i, quotient, eq); end
      if (remainder !== er) begin n_bad++; $display("FAIL bp%0d_r got %h want %h", i, remainder, er); end
    end
    in_valid = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_queue out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_reset_mid_run;
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    sgn      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_in_ready got %b want 1", in_ready); end
    if (quotient !== '0) begin n_bad++; $display("FAIL rr_q got %h want 0", quotient); end
    if (remainder !== '0) begin n_bad++; $display("FAIL rr_r got %h want 0", remainder); end
    if (dz !== 1'b0) begin n_bad++; $display("FAIL rr_dz got %b want 0", dz); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_release_in_ready got %b want 1", in_ready); end
    ref_div(32'hFFFFFFFF, 32'h10, 1'b0, eq, er, ez);
    do_op(32'hFFFFFFFF, 32'h10, 1'b0, lat);
    n_cmp += 2;
    if (quotient !== eq) begin n_bad++; $display("FAIL rr_after_q got %h want %h", quotient, eq); end
    if (remainder !== er) begin n_bad++; $display("FAIL rr_after_r got %h want %h", remainder, er); end
    consume();
  endtask
  task automatic test_signed;
    logic [W-1:0] tn [6];
    logic [W-1:0] td [6];
    logic [W-1:0] n, d, eq, er;
    logic         ez;
    int           lat, elat;
    tn = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFFB, 32'h80000000};
    td = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd1};
    for (int i = 0; i < 66; i++) begin
      n = (i < 6) ? tn[i] : W'($urandom);
      d = (i < 6) ? td[i] : (W'($urandom) >> $urandom_range(0, 31));
      if (i >= 6 && d == '0) d = 32'hFFFFFFF3;
      ref_div(n, d, 1'b1, eq, er, ez);
      elat = ez ? 0 : W + 1;
      do_op(n, d, 1'b1, lat);
      n_cmp += 4;
      if (quotient !== eq) begin n_bad++; $display("FAIL sgn%0d_q %h/%h got %h want %h", i, n, d, quotient, eq); end
      if (remainder !== er) begin n_bad++; $display("FAIL sgn%0d_r %h/%h got %h want %h", i, n, d, remainder, er); end
      if (dz !== ez) begin n_bad++; $display("FAIL sgn%0d_dz got %b want %b", i, dz, ez); end
      if (lat !== elat) begin n_bad++; $display("FAIL sgn%0d_latency got %0d want %0d", i, lat, elat); end
      consume();
    end
  endtask
  task automatic test_back_to_back;
    logic [W-1:0] n, d, eq, er;
    logic         ez;
    logic [63:0]  recon;
    int           t;
    out_ready = 1'b1;
    sgn = 1'b0;
    for (int i = 0; i < 600; i++) begin
      n = $urandom;
      d = (i % 3 == 0) ? W'($urandom) : (i % 3 == 1) ? W'($urandom_range(1, 255)) : (W'($urandom) >> $urandom_range(0, 31));
      if (d == '0) d = 32'd1;
      ref_div(n, d, 1'b0, eq, er, ez);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      dividend = n;
      divisor  = d;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      recon = 64'(quotient) * 64'(d) + 64'(remainder);
      n_cmp += 4;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b%0d_timeout out_valid got %b want 1", i, out_valid); end
      if (recon !== 64'(n)) begin n_bad++; $display("FAIL b2b%0d_invariant %h/%h q*d+r got %h want %h", i, n, d, recon, n); end
      if (!(remainder < d)) begin n_bad++; $display("FAIL b2b%0d_rem_bound r got %h want below %h", i, remainder, d); end
      if (quotient !== eq || remainder !== er || dz !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b%0d_result %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=0", i, n, d, quotient, remainder, dz, eq, er);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_reset_mid_run();
    test_signed();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
